// File: rtl/square_iterative.sv
`default_nettype none
// ============================================================================
// Module   : square_iterative
// Purpose  : Iterative shift-and-add unsigned squarer. Accepts a ROOT_BITS-bit
//            root and returns root*root as a RADICAND_BITS-bit radicand, one
//            partial product per clock (one result per ROOT_BITS+2 edges when
//            issued back to back).
// Ports    : clk        - rising-edge clock
//            rst        - synchronous, active-high reset
//            start      - request, sampled only while ready=1
//            root       - unsigned operand, captured on an accepted start
//            ready      - high while idle; start is accepted this cycle
//            data_valid - one-cycle pulse when radicand is updated
//            radicand   - square of the root of the last completed operation
// Revision : 1.0 - initial release
// ============================================================================
module square_iterative #(
   parameter int RADICAND_BITS = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [RADICAND_BITS/2-1:0]   root,
   output logic                         ready,
   output logic                         data_valid,
   output logic [RADICAND_BITS-1:0]     radicand
);

   localparam int ROOT_BITS = RADICAND_BITS / 2;
   localparam int CNT_BITS  = $clog2(ROOT_BITS + 1);
   // Count value at the start of the final RUN edge; that edge moves to DONE.
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(ROOT_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                     state_q;
   logic [RADICAND_BITS-1:0]   mcand_q;
   logic [RADICAND_BITS-1:0]   acc_q;
   logic [ROOT_BITS-1:0]       mplier_q;
   logic [CNT_BITS-1:0]        cnt_q;
   logic [RADICAND_BITS-1:0]   radicand_q;
   logic                       data_valid_q;
   logic                       ready_q;

   logic [RADICAND_BITS-1:0]   acc_d;
   logic [CNT_BITS-1:0]        cnt_d;

   // One partial product per RUN edge: add the shifted multiplicand when the
   // current multiplier LSB is set. The sum fits because
   // (2^ROOT_BITS-1)^2 < 2^RADICAND_BITS.
   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) begin
         acc_d = acc_q + mcand_q;
      end
      cnt_d = cnt_q + CNT_BITS'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         mcand_q      <= '0;
         acc_q        <= '0;
         mplier_q     <= '0;
         cnt_q        <= '0;
         radicand_q   <= '0;
         data_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         data_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mcand_q  <= {{(RADICAND_BITS - ROOT_BITS){1'b0}}, root};
                  mplier_q <= root;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  ready_q  <= 1'b0;
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_d;
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               radicand_q   <= acc_q;
               data_valid_q <= 1'b1;
               ready_q      <= 1'b1;
               state_q      <= S_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ready      = ready_q;
   assign data_valid = data_valid_q;
   assign radicand   = radicand_q;

endmodule
`default_nettype wire

// File: tb/tb_square_iterative.sv
`default_nettype none
// ============================================================================
// Module   : tb_square_iterative
// Purpose  : Self-checking bench for square_iterative. The driver issues
//            operations and pushes expected squares with their due cycle into
//            a scoreboard; an independent monitor pops and compares on every
//            data_valid pulse, and checks ready and the held radicand every
//            cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_square_iterative;

   localparam int RB = 16;
   localparam int RW = RB / 2;

   typedef struct {
      logic [RB-1:0] expv;
      int            due;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [RW-1:0] root;
   logic          ready;
   logic          data_valid;
   logic [RB-1:0] radicand;

   int            cyc;          // posedges seen so far
   int            model_free;   // first edge at which a new start is accepted
   logic [RB-1:0] exp_hold;     // radicand value expected between pulses
   bit            checking;
   int            checks;
   int            errors;
   exp_t          sb[$];

   square_iterative #(.RADICAND_BITS(RB)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .root       (root),
      .ready      (ready),
      .data_valid (data_valid),
      .radicand   (radicand)
   );

   initial begin
      clk = 1'b0;
      cyc = 0;
      forever begin
         #5 clk = 1'b1;
         cyc++;
         #5 clk = 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   // Reference: the square by plain arithmetic.
   function automatic logic [RB-1:0] square_ref(input logic [RW-1:0] r);
      longint unsigned x;
      x = longint'(r);
      return RB'(x * x);
   endfunction

   // Applies one cycle of inputs; must be called right after a negedge.
   // The next active edge is cyc+1.
   task automatic apply(input logic s, input logic [RW-1:0] r, input logic rs);
      start = s;
      root  = r;
      rst   = rs;
      if (rs) begin
         sb.delete();
         model_free = cyc + 2;
         exp_hold   = '0;
      end else if (s && (cyc + 1 >= model_free)) begin
         sb.push_back('{expv: square_ref(r), due: cyc + 1 + RW + 1});
         model_free = cyc + 1 + RW + 2;
      end
   endtask

   task automatic drive(input logic s, input logic [RW-1:0] r, input logic rs);
      @(negedge clk);
      #1;
      apply(s, r, rs);
   endtask

   // Waits (start low, root scrambled) until the block is free, then starts.
   task automatic issue(input logic [RW-1:0] r);
      for (int g = 0; g < 4 * (RW + 2); g++) begin
         @(negedge clk);
         #1;
         if (cyc + 1 >= model_free) begin
            apply(1'b1, r, 1'b0);
            return;
         end
         apply(1'b0, RW'($urandom), 1'b0);
      end
      chk("issue_timeout", 64'd0, 64'd1);
   endtask

   // Monitor: compares DUT behaviour against the scoreboard every cycle.
   always @(negedge clk) begin
      exp_t e;
      if (checking) begin
         while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            chk("missing_pulse", 64'(cyc), 64'(e.due));
         end
         chk("ready", 64'(ready), 64'(cyc + 1 >= model_free));
         if (data_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_pulse", 64'(data_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("latency", 64'(cyc), 64'(e.due));
               chk("radicand", 64'(radicand), 64'(e.expv));
               exp_hold = e.expv;
            end
         end else begin
            chk("hold", 64'(radicand), 64'(exp_hold));
         end
      end
   end

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      root       = '0;
      checking   = 1'b0;
      model_free = 0;
      exp_hold   = '0;
      checks     = 0;
      errors     = 0;

      // Reset held for two edges; start asserted during reset must be ignored.
      @(negedge clk);
      #1 start = 1'b1;
      root = RW'(5);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      rst        = 1'b0;
      start      = 1'b0;
      model_free = cyc + 1;
      checking   = 1'b1;

      // Idle with start low: no pulses.
      repeat (5) drive(1'b0, '0, 1'b0);

      // Basic values, issued with gaps.
      issue(RW'(0));
      repeat (RW + 4) drive(1'b0, RW'($urandom), 1'b0);
      issue(RW'(1));
      repeat (RW + 4) drive(1'b0, RW'($urandom), 1'b0);
      issue({RW{1'b1}});
      repeat (RW + 4) drive(1'b0, RW'($urandom), 1'b0);

      // Back to back: second start lands in the data_valid cycle.
      issue(RW'(8'h0C));
      issue(RW'(8'h10));
      repeat (RW + 4) drive(1'b0, '0, 1'b0);

      // Busy ignore: start held with another root through RUN and DONE.
      issue(RW'(3));
      repeat (RW + 1) drive(1'b1, RW'(200), 1'b0);
      repeat (RW + 4) drive(1'b0, '0, 1'b0);

      // Reset at the 4th RUN edge aborts the operation silently.
      issue(RW'(8'hAA));
      repeat (3) drive(1'b0, '0, 1'b0);
      drive(1'b1, RW'(7), 1'b1);
      drive(1'b0, '0, 1'b0);
      issue(RW'(2));
      repeat (RW + 4) drive(1'b0, '0, 1'b0);

      // Exhaustive sweep, back to back.
      for (int r = 0; r < (1 << RW); r++) begin
         issue(RW'(r));
      end

      // Random operands with random gaps and random busy starts.
      for (int n = 0; n < 60; n++) begin
         issue(RW'($urandom));
         for (int k = 0; k < int'($urandom_range(0, RW + 4)); k++) begin
            drive(1'($urandom), RW'($urandom), 1'b0);
         end
      end

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 3 * (RW + 2) && sb.size() > 0; k++) begin
         drive(1'b0, '0, 1'b0);
      end
      repeat (2) drive(1'b0, '0, 1'b0);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
